// File: rtl/alu_pkg.sv
// Shared constants and FSM encoding for the ALU command initiator and its golden model.
package alu_pkg;
   localparam int OPND_W = 3;
   localparam int RES_W  = 6;
   localparam int SET_W  = 4;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_MUL  = 3'b011;
   localparam logic [2:0] OP_SHR  = 3'b100;
   localparam logic [2:0] OP_SHL  = 3'b101;
   localparam logic [2:0] OP_XNOR = 3'b110;
   localparam logic [2:0] OP_SEQ  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } state_e;
endpackage

// File: rtl/alu_cmd_initiator_if.sv
// Command, ALU drive and response signals between the initiator and its surroundings.
interface alu_cmd_initiator_if;
   import alu_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_op;
   logic [OPND_W-1:0] cmd_a;
   logic [OPND_W-1:0] cmd_b;
   logic [2:0]        alu_op;
   logic [OPND_W-1:0] alu_a;
   logic [OPND_W-1:0] alu_b;
   logic [RES_W-1:0]  alu_f;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [RES_W-1:0]  rsp_f;
   logic              rsp_mismatch;

   modport master (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_f, rsp_ready,
      output cmd_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_f, rsp_mismatch
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_a, cmd_b, alu_f, rsp_ready,
      input  cmd_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_f, rsp_mismatch
   );
endinterface

// File: rtl/alu_golden.sv
// Combinational reference ALU: 3-bit operands zero-extended, 6-bit unsigned result.
module alu_golden
   import alu_pkg::*;
(
   input  logic [2:0]        op,
   input  logic [OPND_W-1:0] a,
   input  logic [OPND_W-1:0] b,
   output logic [RES_W-1:0]  f
);
   logic [RES_W-1:0] ax_s;
   logic [RES_W-1:0] bx_s;

   assign ax_s = {3'b000, a};
   assign bx_s = {3'b000, b};

   // Expected result per opcode; arithmetic wraps modulo 64.
   always_comb begin
      f = 6'd0;
      case (op)
         OP_NOP:  f = 6'd0;
         OP_ADD:  f = ax_s + bx_s;
         OP_SUB:  f = ax_s - bx_s;
         OP_MUL:  f = ax_s * bx_s;
         OP_SHR:  f = ax_s >> b;
         OP_SHL:  f = ax_s << b;
         OP_XNOR: f = {3'b000, ~(a ^ b)};
         OP_SEQ:  f = (a == b) ? 6'd1 : 6'd0;
         default: f = 6'd0;
      endcase
   end
endmodule

// File: rtl/alu_cmd_initiator.sv
// Drives one command into the combinational ALU, waits SETTLE_CYCLES, captures and
// returns the result, and counts disagreements with the golden model.
module alu_cmd_initiator
   import alu_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_cmd_initiator_if.master  bus,
   output logic [CNT_W-1:0]     err_count
);
   state_e            state_q, state_d;
   logic [SET_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        alu_op_q, alu_op_d;
   logic [OPND_W-1:0] alu_a_q, alu_a_d;
   logic [OPND_W-1:0] alu_b_q, alu_b_d;
   logic [RES_W-1:0]  rsp_f_q, rsp_f_d;
   logic              rsp_mismatch_q, rsp_mismatch_d;
   logic [CNT_W-1:0]  err_count_q, err_count_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [RES_W-1:0]  golden_f_s;
   logic              mismatch_s;

   alu_golden u_golden (
      .op (alu_op_q),
      .a  (alu_a_q),
      .b  (alu_b_q),
      .f  (golden_f_s)
   );

   assign mismatch_s = (bus.alu_f != golden_f_s);

   // Next-state and datapath updates for the IDLE/SETTLE/RESP sequence.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      alu_op_d       = alu_op_q;
      alu_a_d        = alu_a_q;
      alu_b_d        = alu_b_q;
      rsp_f_d        = rsp_f_q;
      rsp_mismatch_d = rsp_mismatch_q;
      err_count_d    = err_count_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               alu_op_d = bus.cmd_op;
               alu_a_d  = bus.cmd_a;
               alu_b_d  = bus.cmd_b;
               cnt_d    = SET_W'(SETTLE_CYCLES - 1);
               state_d  = ST_SETTLE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == {SET_W{1'b0}}) begin
               rsp_f_d        = bus.alu_f;
               rsp_mismatch_d = mismatch_s;
               if (mismatch_s && (err_count_q != {CNT_W{1'b1}})) begin
                  err_count_d = err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  err_count_d = err_count_q;
               end
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - {{(SET_W-1){1'b0}}, 1'b1};
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Handshake flags follow the next state so they are clean registered outputs.
      cmd_ready_d = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         cnt_q          <= {SET_W{1'b0}};
         alu_op_q       <= 3'b000;
         alu_a_q        <= {OPND_W{1'b0}};
         alu_b_q        <= {OPND_W{1'b0}};
         rsp_f_q        <= {RES_W{1'b0}};
         rsp_mismatch_q <= 1'b0;
         err_count_q    <= {CNT_W{1'b0}};
         cmd_ready_q    <= 1'b0;
         rsp_valid_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         alu_op_q       <= alu_op_d;
         alu_a_q        <= alu_a_d;
         alu_b_q        <= alu_b_d;
         rsp_f_q        <= rsp_f_d;
         rsp_mismatch_q <= rsp_mismatch_d;
         err_count_q    <= err_count_d;
         cmd_ready_q    <= cmd_ready_d;
         rsp_valid_q    <= rsp_valid_d;
      end
   end

   assign bus.cmd_ready    = cmd_ready_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_f        = rsp_f_q;
   assign bus.rsp_mismatch = rsp_mismatch_q;
   assign bus.alu_op       = alu_op_q;
   assign bus.alu_a        = alu_a_q;
   assign bus.alu_b        = alu_b_q;
   assign err_count        = err_count_q;
endmodule

// File: tb/tb_alu_cmd_initiator.sv
// Directed bench: one initiator with a 1-cycle settle time, one with 3, both driven by a bench-side ALU.
module tb_alu_cmd_initiator;
   logic       clk;
   logic       rst_n;
   logic       fault;
   logic [7:0] err1;
   logic [7:0] err3;
   logic [2:0] g_op, g_a, g_b;
   logic [5:0] g_f;
   int         n_checks;
   int         n_err;
   int         hs_count;

   alu_cmd_initiator_if if1 ();
   alu_cmd_initiator_if if3 ();

   alu_cmd_initiator #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (
      .clk (clk), .rst_n (rst_n), .bus (if1.master), .err_count (err1)
   );

   alu_cmd_initiator #(.SETTLE_CYCLES(3), .CNT_W(8)) dut3 (
      .clk (clk), .rst_n (rst_n), .bus (if3.master), .err_count (err3)
   );

   alu_golden u_gold (.op (g_op), .a (g_a), .b (g_b), .f (g_f));

   // Independent behavioural ALU standing in for the real ALU instance.
   function automatic logic [5:0] tb_alu(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b);
      int ai, bi, r;
      ai = int'(a);
      bi = int'(b);
      case (op)
         3'd1:    r = ai + bi;
         3'd2:    r = ai - bi + 64;
         3'd3:    r = ai * bi;
         3'd4:    r = ai >> bi;
         3'd5:    r = ai << bi;
         3'd6:    r = 7 - (ai ^ bi);
         3'd7:    r = (ai == bi) ? 1 : 0;
         default: r = 0;
      endcase
      return r[5:0];
   endfunction

   assign if1.alu_f = fault ? 6'h3F : tb_alu(if1.alu_op, if1.alu_a, if1.alu_b);
   assign if3.alu_f = tb_alu(if3.alu_op, if3.alu_a, if3.alu_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (if1.rsp_valid && if1.rsp_ready) hs_count <= hs_count + 1;
   end

   typedef struct {
      logic [2:0] op;
      logic [2:0] a;
      logic [2:0] b;
      logic [5:0] f;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_ready1();
      int n;
      n = 0;
      while (!if1.cmd_ready && n < 20) begin
         tick();
         n++;
      end
      check("cmd_ready wait", 32'(if1.cmd_ready), 32'd1);
   endtask

   // One command on the 1-cycle instance with rsp_ready already high.
   task automatic run_vec(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                          input logic [5:0] ef, input logic emm, input string nm);
      wait_ready1();
      if1.cmd_valid = 1'b1;
      if1.cmd_op = op;
      if1.cmd_a = a;
      if1.cmd_b = b;
      tick();
      if1.cmd_valid = 1'b0;
      check({nm, " alu_op"}, 32'(if1.alu_op), 32'(op));
      check({nm, " alu_a"}, 32'(if1.alu_a), 32'(a));
      check({nm, " alu_b"}, 32'(if1.alu_b), 32'(b));
      check({nm, " rsp_valid early"}, 32'(if1.rsp_valid), 32'd0);
      check({nm, " cmd_ready busy"}, 32'(if1.cmd_ready), 32'd0);
      tick();
      check({nm, " rsp_valid"}, 32'(if1.rsp_valid), 32'd1);
      check({nm, " rsp_f"}, 32'(if1.rsp_f), 32'(ef));
      check({nm, " rsp_mismatch"}, 32'(if1.rsp_mismatch), 32'(emm));
      check({nm, " exclusive"}, 32'(if1.rsp_valid & if1.cmd_ready), 32'd0);
      tick();
      check({nm, " rsp_valid drop"}, 32'(if1.rsp_valid), 32'd0);
   endtask

   vec_t vecs[8];
   int   hs_before;
   int   n;

   initial begin
      n_checks = 0;
      n_err = 0;
      hs_count = 0;
      fault = 1'b0;
      rst_n = 1'b0;
      g_op = 3'd0; g_a = 3'd0; g_b = 3'd0;
      if1.cmd_valid = 1'b1; if1.cmd_op = 3'd1; if1.cmd_a = 3'd5; if1.cmd_b = 3'd5;
      if1.rsp_ready = 1'b1;
      if3.cmd_valid = 1'b0; if3.cmd_op = 3'd0; if3.cmd_a = 3'd0; if3.cmd_b = 3'd0;
      if3.rsp_ready = 1'b1;

      vecs[0] = '{3'b001, 3'd7, 3'd1, 6'd8};
      vecs[1] = '{3'b010, 3'd3, 3'd6, 6'd61};
      vecs[2] = '{3'b011, 3'd3, 3'd6, 6'd18};
      vecs[3] = '{3'b100, 3'd4, 3'd2, 6'd1};
      vecs[4] = '{3'b101, 3'd1, 3'd2, 6'd4};
      vecs[5] = '{3'b110, 3'd7, 3'd5, 6'd5};
      vecs[6] = '{3'b111, 3'd3, 3'd3, 6'd1};
      vecs[7] = '{3'b111, 3'd0, 3'd3, 6'd0};

      // Reset held for three cycles with a command offered.
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset cmd_ready", 32'(if1.cmd_ready), 32'd0);
         check("reset rsp_valid", 32'(if1.rsp_valid), 32'd0);
      end
      check("reset alu", 32'({if1.alu_op, if1.alu_a, if1.alu_b}), 32'd0);
      check("reset err_count", 32'(err1), 32'd0);
      check("reset rsp_f", 32'(if1.rsp_f), 32'd0);
      rst_n = 1'b1;
      if1.cmd_valid = 1'b0;
      tick();
      check("release cmd_ready", 32'(if1.cmd_ready), 32'd1);

      // Opcode table against the golden model and the full initiator path.
      for (int i = 0; i < 8; i++) begin
         g_op = vecs[i].op; g_a = vecs[i].a; g_b = vecs[i].b;
         #1;
         check($sformatf("golden v%0d", i), 32'(g_f), 32'(vecs[i].f));
         run_vec(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].f, 1'b0, $sformatf("v%0d", i));
      end
      check("err_count clean", 32'(err1), 32'd0);

      // Backpressure with a competing command waiting.
      if1.rsp_ready = 1'b0;
      wait_ready1();
      if1.cmd_valid = 1'b1; if1.cmd_op = 3'b001; if1.cmd_a = 3'd1; if1.cmd_b = 3'd2;
      tick();
      if1.cmd_op = 3'b001; if1.cmd_a = 3'd3; if1.cmd_b = 3'd3;
      tick();
      for (int i = 0; i < 10; i++) begin
         check("bp rsp_valid", 32'(if1.rsp_valid), 32'd1);
         check("bp rsp_f", 32'(if1.rsp_f), 32'd3);
         check("bp cmd_ready", 32'(if1.cmd_ready), 32'd0);
         check("bp alu_a held", 32'(if1.alu_a), 32'd1);
         tick();
      end
      if1.rsp_ready = 1'b1;
      tick();
      check("bp release rsp_valid", 32'(if1.rsp_valid), 32'd0);
      check("bp release cmd_ready", 32'(if1.cmd_ready), 32'd1);
      check("bp not yet accepted", 32'(if1.alu_a), 32'd1);
      tick();
      if1.cmd_valid = 1'b0;
      check("bp accepted alu_a", 32'(if1.alu_a), 32'd3);
      tick();
      check("bp second rsp_f", 32'(if1.rsp_f), 32'd6);
      tick();

      // Faulty ALU: every result mismatches, counter saturates.
      fault = 1'b1;
      for (int i = 0; i < 300; i++) begin
         run_vec(3'b001, 3'(i), 3'(i >> 3), 6'h3F, 1'b1, "fault");
         check($sformatf("err_count %0d", i), 32'(err1), (i < 255) ? 32'(i + 1) : 32'd255);
      end
      fault = 1'b0;

      // Reset while a response is pending.
      if1.rsp_ready = 1'b0;
      wait_ready1();
      if1.cmd_valid = 1'b1; if1.cmd_op = 3'b011; if1.cmd_a = 3'd7; if1.cmd_b = 3'd7;
      tick();
      if1.cmd_valid = 1'b0;
      tick();
      check("midrst in RESP", 32'(if1.rsp_valid), 32'd1);
      check("midrst rsp_f", 32'(if1.rsp_f), 32'd49);
      hs_before = hs_count;
      rst_n = 1'b0;
      tick();
      if1.rsp_ready = 1'b1;
      check("midrst rsp_valid", 32'(if1.rsp_valid), 32'd0);
      check("midrst rsp_f cleared", 32'(if1.rsp_f), 32'd0);
      check("midrst mismatch", 32'(if1.rsp_mismatch), 32'd0);
      check("midrst alu", 32'({if1.alu_op, if1.alu_a, if1.alu_b}), 32'd0);
      check("midrst err_count", 32'(err1), 32'd0);
      check("midrst cmd_ready", 32'(if1.cmd_ready), 32'd0);
      rst_n = 1'b1;
      tick();
      check("midrst no handshake", 32'(hs_count), 32'(hs_before));
      check("midrst rsp_valid after", 32'(if1.rsp_valid), 32'd0);
      run_vec(3'b001, 3'd2, 3'd2, 6'd4, 1'b0, "after rst");

      // Three-cycle settle instance.
      n = 0;
      while (!if3.cmd_ready && n < 20) begin
         tick();
         n++;
      end
      check("s3 cmd_ready", 32'(if3.cmd_ready), 32'd1);
      if3.cmd_valid = 1'b1; if3.cmd_op = 3'b001; if3.cmd_a = 3'd5; if3.cmd_b = 3'd2;
      tick();
      if3.cmd_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("s3 alu c%0d", i), 32'({if3.alu_op, if3.alu_a, if3.alu_b}),
               32'({3'b001, 3'd5, 3'd2}));
         check($sformatf("s3 rsp_valid c%0d", i), 32'(if3.rsp_valid), (i == 2) ? 32'd0 : 32'd0);
         tick();
      end
      check("s3 rsp_valid", 32'(if3.rsp_valid), 32'd1);
      check("s3 rsp_f", 32'(if3.rsp_f), 32'd7);
      check("s3 mismatch", 32'(if3.rsp_mismatch), 32'd0);
      check("s3 err_count", 32'(err3), 32'd0);
      tick();
      check("s3 rsp_valid drop", 32'(if3.rsp_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
